// File: rtl/xnor_sum_argmax.sv
// Sequential argmax over the M packed lane sums from the XNOR-accumulate layer.
// Define ARGMAX_SIGNED_EN to treat lanes as two's-complement. Leave it undefined for unsigned lanes.
module xnor_sum_argmax #(
    parameter int unsigned M  = 4,
    parameter int unsigned W  = 4,
    parameter int unsigned IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [W*M-1:0]   sums,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    class_idx,
    output logic [W-1:0]     max_val
);

    localparam logic [IW-1:0] LAST = IW'(M - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W*M-1:0]  sums_q;
    logic [W-1:0]    best_val;
    logic [IW-1:0]   best_idx;
    logic [IW-1:0]   cnt;

    logic [W*M-1:0]  sums_n;
    logic [W-1:0]    best_val_n;
    logic [IW-1:0]   best_idx_n;
    logic [IW-1:0]   cnt_n;
    logic            busy_n;
    logic            done_n;
    logic [IW-1:0]   class_idx_n;
    logic [W-1:0]    max_val_n;

    logic [W-1:0]    lanes_c [M];
    logic [W-1:0]    lane_c;
    logic            gt_c;

    // Unpack the latched vector so the current lane can be selected by cnt
    always_comb begin
        for (int k = 0; k < int'(M); k++) begin
            lanes_c[k] = sums_q[k*W +: W];
        end
    end

    assign lane_c = lanes_c[cnt];

    // Strictly-greater compare, so ties keep the lowest index
`ifdef ARGMAX_SIGNED_EN
    assign gt_c = $signed(lane_c) > $signed(best_val);
`else
    assign gt_c = lane_c > best_val;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (M > 1)) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (cnt == LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values; done defaults low so it lasts one enabled cycle
    always_comb begin
        sums_n      = sums_q;
        best_val_n  = best_val;
        best_idx_n  = best_idx;
        cnt_n       = cnt;
        busy_n      = busy;
        done_n      = 1'b0;
        class_idx_n = class_idx;
        max_val_n   = max_val;
        case (state)
            IDLE: begin
                if (start) begin
                    sums_n     = sums;
                    best_val_n = sums[W-1:0];
                    best_idx_n = '0;
                    cnt_n      = IW'(1);
                    if (M == 1) begin
                        done_n      = 1'b1;
                        class_idx_n = '0;
                        max_val_n   = sums[W-1:0];
                    end else begin
                        busy_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (gt_c) begin
                    best_val_n = lane_c;
                    best_idx_n = cnt;
                end
                cnt_n = cnt + IW'(1);
                if (cnt == LAST) begin
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                    class_idx_n = gt_c ? cnt : best_idx;
                    max_val_n   = gt_c ? lane_c : best_val;
                end
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; all hold while enable is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sums_q    <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
        end else if (enable) begin
            sums_q    <= sums_n;
            best_val  <= best_val_n;
            best_idx  <= best_idx_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            class_idx <= class_idx_n;
            max_val   <= max_val_n;
        end
    end

endmodule

// File: tb/tb_xnor_sum_argmax.sv
// Bench for xnor_sum_argmax: transaction-level argmax model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_xnor_sum_argmax;

    localparam int unsigned M  = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b1;
    logic           start = 1'b0;
    logic [W*M-1:0] sums = '0;
    logic           busy;
    logic           done;
    logic [IW-1:0]  class_idx;
    logic [W-1:0]   max_val;

    int checks = 0;
    int failures = 0;

    xnor_sum_argmax #(.M(M), .W(W), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .sums      (sums),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .max_val   (max_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference argmax: scan all lanes, keep the first strictly-greatest one
    function automatic logic [IW+W-1:0] ref_argmax(input logic [W*M-1:0] s);
        logic [W-1:0]  bv;
        logic [IW-1:0] bi;
        logic [W-1:0]  v;
        bv = s[W-1:0];
        bi = '0;
        for (int k = 1; k < int'(M); k++) begin
            v = s[k*W +: W];
`ifdef ARGMAX_SIGNED_EN
            if ($signed(v) > $signed(bv)) begin
`else
            if (v > bv) begin
`endif
                bv = v;
                bi = IW'(k);
            end
        end
        return {bi, bv};
    endfunction

    // Transaction model: a request completes M-1 enabled edges after acceptance
    logic          m_busy;
    logic          m_done;
    logic [IW-1:0] m_idx;
    logic [W-1:0]  m_val;
    logic [IW+W-1:0] m_pend;
    int            m_rem;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_idx  <= '0;
            m_val  <= '0;
            m_pend <= '0;
            m_rem  <= 0;
        end else if (enable) begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_idx  <= m_pend[IW+W-1:W];
                    m_val  <= m_pend[W-1:0];
                end
            end else if (start) begin
                m_pend <= ref_argmax(sums);
                m_busy <= 1'b1;
                m_rem  <= int'(M) - 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("class_idx", 32'(class_idx), 32'(m_idx));
        check("max_val", 32'(max_val), 32'(m_val));
    end

    // Issue a start, optionally stall enable for 'stall' cycles, and wait for done
    task automatic run_scan(input logic [W*M-1:0] s, input int stall,
                            output logic [IW-1:0] idx, output logic [W-1:0] val,
                            output int lat, output int bcyc);
        bit got;
        got = 0;
        lat = 0;
        bcyc = 0;
        idx = '0;
        val = '0;
        @(negedge clk);
        sums = s;
        start = 1'b1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) bcyc++;
            if (done) begin
                got = 1;
                lat = k;
                idx = class_idx;
                val = max_val;
            end
            if (stall > 0 && k == 1) enable = 1'b0;
            if (stall > 0 && k == 1 + stall) enable = 1'b1;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_val;
    int            r_lat;
    int            r_busy;
    int            n_done;

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(class_idx), 32'd0);
        check("rst_val", 32'(max_val), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic scan: 3A51 -> lanes 1,5,A,3
        run_scan(16'h3A51, 0, r_idx, r_val, r_lat, r_busy);
`ifdef ARGMAX_SIGNED_EN
        check("basic_idx", 32'(r_idx), 32'd1);
        check("basic_val", 32'(r_val), 32'h5);
`else
        check("basic_idx", 32'(r_idx), 32'd2);
        check("basic_val", 32'(r_val), 32'hA);
`endif
        check("basic_latency", 32'(r_lat), 32'd4);
        check("basic_busy_cycles", 32'(r_busy), 32'd3);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Ties keep the lowest index
        run_scan(16'h7717, 0, r_idx, r_val, r_lat, r_busy);
        check("tie1_idx", 32'(r_idx), 32'd0);
        check("tie1_val", 32'(r_val), 32'h7);
        run_scan(16'h0F0F, 0, r_idx, r_val, r_lat, r_busy);
`ifdef ARGMAX_SIGNED_EN
        check("tie2_idx", 32'(r_idx), 32'd1);
        check("tie2_val", 32'(r_val), 32'h0);
`else
        check("tie2_idx", 32'(r_idx), 32'd0);
        check("tie2_val", 32'(r_val), 32'hF);
`endif

        // Stall for 5 cycles mid-scan delays done by exactly 5
        run_scan(16'h3A51, 5, r_idx, r_val, r_lat, r_busy);
        check("stall_latency", 32'(r_lat), 32'd9);
        check("stall_busy_cycles", 32'(r_busy), 32'd8);
`ifndef ARGMAX_SIGNED_EN
        check("stall_idx", 32'(r_idx), 32'd2);
        check("stall_val", 32'(r_val), 32'hA);
`endif

        // Start during scan and on the done edge is ignored
        @(negedge clk);
        sums = 16'h3A51;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        @(negedge clk);
        sums = 16'hF000;
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin
                n_done++;
                r_idx = class_idx;
                r_val = max_val;
            end
        end
        check("busy_start_done_count", 32'(n_done), 32'd1);
`ifndef ARGMAX_SIGNED_EN
        check("busy_start_idx", 32'(r_idx), 32'd2);
        check("busy_start_val", 32'(r_val), 32'hA);
`endif
        run_scan(16'hF000, 0, r_idx, r_val, r_lat, r_busy);
`ifdef ARGMAX_SIGNED_EN
        check("fresh_idx", 32'(r_idx), 32'd0);
        check("fresh_val", 32'(r_val), 32'h0);
`else
        check("fresh_idx", 32'(r_idx), 32'd3);
        check("fresh_val", 32'(r_val), 32'hF);
`endif

        // Reset mid-scan clears outputs immediately and no done follows
        @(negedge clk);
        sums = 16'h3A51;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_idx", 32'(class_idx), 32'd0);
        check("midrst_val", 32'(max_val), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
